// File: rtl/dffram_dp.sv
// Dual-port word memory: port A read/write with byte enables, port B read-only.
// Optional hardware zeroization sweeps every word once after reset before granting access.
module dffram_dp #(
    parameter int DW        = 32,
    parameter int DEPTH     = 4096,
    parameter int INIT_ZERO = 1,
    localparam int AW       = $clog2(DEPTH),
    localparam int BW       = DW / 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic          init_busy_o,
    input  logic          a_req_i,
    output logic          a_gnt_o,
    input  logic          a_we_i,
    input  logic [BW-1:0] a_be_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_wdata_i,
    output logic          a_rvalid_o,
    output logic [DW-1:0] a_rdata_o,
    input  logic          b_req_i,
    output logic          b_gnt_o,
    input  logic [AW-1:0] b_addr_i,
    output logic          b_rvalid_o,
    output logic [DW-1:0] b_rdata_o
);

    if ((DW % 8) != 0) begin : g_err_dw
        $error("dffram_dp: DW must be a multiple of 8");
    end
    if (DEPTH < 2) begin : g_err_depth_min
        $error("dffram_dp: DEPTH must be at least 2");
    end
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_err_depth_pow2
        $error("dffram_dp: DEPTH must be a power of two");
    end

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [0:0] ST_RESET = (INIT_ZERO != 0) ? ST_INIT : ST_READY;

    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic          a_acc;
    logic          b_acc;
    logic [DW-1:0] mem [DEPTH];

    // Handshake: an access is taken on a rising edge where req and gnt are both high.
    // gnt depends only on the FSM state; rvalid pulses for one cycle on the following edge.
    assign init_busy_o = (state == ST_INIT);
    assign a_gnt_o     = (state == ST_READY);
    assign b_gnt_o     = (state == ST_READY);
    assign a_acc       = a_req_i & a_gnt_o;
    assign b_acc       = b_req_i & b_gnt_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_RESET;
            cnt   <= '0;
        end else if (state == ST_INIT) begin
            if (cnt == AW'(DEPTH - 1)) begin
                state <= ST_READY;
                cnt   <= '0;
            end else begin
                cnt <= cnt + AW'(1);
            end
        end
    end

    // Storage has no reset; only the INIT sweep clears it.
    always_ff @(posedge clk_i) begin
        if (state == ST_INIT) begin
            mem[cnt] <= '0;
        end else if (a_acc && a_we_i) begin
            for (int i = 0; i < BW; i++) begin
                if (a_be_i[i]) begin
                    mem[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Read data is sampled before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_rvalid_o <= 1'b0;
            b_rvalid_o <= 1'b0;
            a_rdata_o  <= '0;
            b_rdata_o  <= '0;
        end else begin
            a_rvalid_o <= a_acc;
            b_rvalid_o <= b_acc;
            if (a_acc) begin
                a_rdata_o <= mem[a_addr_i];
            end
            if (b_acc) begin
                b_rdata_o <= mem[b_addr_i];
            end
        end
    end

endmodule

// File: doc/dffram_dp.md
DFFRAM_DP -- requirements
Module: dffram_dp

Interface
REQ-001 Parameter DW, default 32: data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 4096: number of words; SHALL be a power of two and at least 2.
REQ-003 Parameter INIT_ZERO, default 1: 1 SHALL enable hardware zeroization after reset; 0 SHALL disable it.
REQ-004 Derived AW = clog2(DEPTH) and BW = DW/8 SHALL be used only as widths.
REQ-005 clk_i  in  1  single clock; all state SHALL change on the rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-007 init_busy_o  out  1  high while zeroization is in progress.
REQ-008 a_req_i  in  1  port A (read/write) request.
REQ-009 a_gnt_o  out  1  port A grant.
REQ-010 a_we_i  in  1  port A write enable.
REQ-011 a_be_i  in  BW  port A byte-write mask; bit n covers data bits [8n+7:8n].
REQ-012 a_addr_i  in  AW  port A word address.
REQ-013 a_wdata_i  in  DW  port A write data.
REQ-014 a_rvalid_o  out  1  port A response valid.
REQ-015 a_rdata_o  out  DW  port A read data.
REQ-016 b_req_i  in  1  port B (read-only) request.
REQ-017 b_gnt_o  out  1  port B grant.
REQ-018 b_addr_i  in  AW  port B word address.
REQ-019 b_rvalid_o  out  1  port B response valid.
REQ-020 b_rdata_o  out  DW  port B read data.

Function
REQ-021 Control SHALL be a two-state FSM with states INIT and READY.
REQ-022 After reset the FSM SHALL enter INIT when INIT_ZERO=1 and READY when INIT_ZERO=0.
REQ-023 In INIT, an address counter starting at 0 SHALL write all-zero data to one word per cycle.
REQ-024 The INIT to READY transition SHALL occur in the cycle that writes address DEPTH-1, so INIT lasts exactly DEPTH cycles.
REQ-025 init_busy_o SHALL equal (state==INIT).
REQ-026 a_gnt_o and b_gnt_o SHALL equal (state==READY) combinationally and SHALL not depend on the req inputs.
REQ-027 An access SHALL be accepted on a rising edge where req and gnt are both high; requests without grant SHALL be dropped with no side effect.
REQ-028 Every accepted access, read or write, SHALL produce rvalid high for exactly one cycle, one cycle after acceptance.
REQ-029 On an accepted access, rdata SHALL carry the word stored at the address before that cycle's write (read-first).
REQ-030 On an accepted port A write, the bytes selected by a_be_i SHALL be updated and the other bytes SHALL be retained.
REQ-031 A write with a_be_i=0 SHALL leave memory unchanged and still return rvalid.
REQ-032 When port A writes and port B reads the same address in the same cycle, port B SHALL return the old word.
REQ-033 Port B SHALL observe the new word from the following cycle onward.
REQ-034 rdata outputs SHALL hold their last value while rvalid is low.
REQ-035 Both ports SHALL sustain one accepted access per cycle each, back-to-back, with no bubbles.
REQ-036 Parameter violations (DW%8!=0, DEPTH not a power of two, DEPTH<2) SHALL be flagged at elaboration.

Reset
REQ-037 While rst_ni is low, a_rvalid_o=0, b_rvalid_o=0, a_rdata_o=0, b_rdata_o=0, the address counter=0, and the FSM SHALL be in INIT (INIT_ZERO=1) or READY (INIT_ZERO=0).
REQ-038 Memory contents SHALL not be reset by rst_ni; clearing SHALL occur only through INIT.
REQ-039 Reset asserted mid-INIT or mid-access SHALL abort the operation; after release, zeroization SHALL restart from address 0 and no response SHALL be issued for the aborted access.

Verification (DW=32, DEPTH=16, INIT_ZERO=1)
REQ-040 Release reset -> init_busy_o high for exactly 16 cycles with both grants low; then B read addr 5 -> b_rvalid_o one cycle later with b_rdata_o=0x00000000.
REQ-041 A write 0xDEADBEEF to addr 3 with be=4'b1111, then A write 0x000000AA to addr 3 with be=4'b0001, then A read addr 3 -> a_rdata_o=0xDEADBEAA.
REQ-042 Same cycle: A write 0x12345678 to addr 7 and B read addr 7 -> b_rdata_o=0x00000000; B read addr 7 in the next cycle -> 0x12345678.
REQ-043 Assert rst_ni low when the INIT counter reaches 8, then release -> counter restarts at 0, init_busy_o high for 16 more cycles, and a read of addr 12 (previously written 0x55) returns 0.
REQ-044 a_req_i high during INIT with write 0xFFFFFFFF to addr 2 -> no a_rvalid_o, and a read of addr 2 after INIT returns 0.
REQ-045 A write 0xCAFEF00D to addr 9 with be=4'b0000 -> a_rvalid_o pulses one cycle later, and a read of addr 9 returns its prior value unchanged.
